// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// funct encodings, FSM state type and funct decode helpers.
package ex_muldiv_unit_pkg;

    localparam logic [5:0] FunctMthi  = 6'h11;
    localparam logic [5:0] FunctMtlo  = 6'h13;
    localparam logic [5:0] FunctMult  = 6'h18;
    localparam logic [5:0] FunctMultu = 6'h19;
    localparam logic [5:0] FunctDiv   = 6'h1A;
    localparam logic [5:0] FunctDivu  = 6'h1B;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIter = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic logic is_muldiv(input logic [5:0] funct);
        return (funct == FunctMult) || (funct == FunctMultu) ||
               (funct == FunctDiv)  || (funct == FunctDivu);
    endfunction

    function automatic logic is_div_op(input logic [5:0] funct);
        return (funct == FunctDiv) || (funct == FunctDivu);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] funct);
        return (funct == FunctMult) || (funct == FunctDiv);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side connection of the multiply/divide unit: id_ex operands and
// control in, stall/done and the architectural HI/LO registers out.
interface ex_muldiv_unit_if #(
    parameter int unsigned BUS_SIZE = 32
);
    logic                i_enable;
    logic                i_flush;
    logic                i_start;
    logic [5:0]          i_funct;
    logic [BUS_SIZE-1:0] i_bus_a;
    logic [BUS_SIZE-1:0] i_bus_b;
    logic                o_stall;
    logic                o_done;
    logic                o_div_by_zero;
    logic [BUS_SIZE-1:0] o_hi;
    logic [BUS_SIZE-1:0] o_lo;

    modport master (
        output i_enable, i_flush, i_start, i_funct, i_bus_a, i_bus_b,
        input  o_stall, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_enable, i_flush, i_start, i_funct, i_bus_a, i_bus_b,
        output o_stall, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Magnitudes are processed one bit
// per cycle (shift-add / restoring division), then a FIX cycle applies the signs.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned BUS_SIZE = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    ex_muldiv_unit_if.slave  bus
);

    localparam int unsigned W    = BUS_SIZE;
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;

    logic             op_signed, op_div, start_muldiv;
    logic [W-1:0]     abs_a, abs_b;
    logic [W:0]       add_sum;
    logic [W:0]       rem_sh;
    logic [W-1:0]     rem_diff;
    logic             sub_ok;
    logic [2*W-1:0]   prod_fixed;

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_signed    = is_signed_op(bus.i_funct);
    assign op_div       = is_div_op(bus.i_funct);
    assign start_muldiv = bus.i_start && is_muldiv(bus.i_funct);
    assign abs_a        = (op_signed && bus.i_bus_a[W-1]) ? -bus.i_bus_a : bus.i_bus_a;
    assign abs_b        = (op_signed && bus.i_bus_b[W-1]) ? -bus.i_bus_b : bus.i_bus_b;

    // acc holds {partial product hi, multiplier} for mul and {remainder, quotient} for div
    assign add_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    assign rem_sh     = acc_q[2*W-1:W-1];
    assign sub_ok     = rem_sh >= {1'b0, opnd_q};
    assign rem_diff   = rem_sh[W-1:0] - opnd_q;
    assign prod_fixed = neg_res_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        if (bus.i_enable) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start && !bus.i_flush) begin
                        if (bus.i_funct == FunctMthi) begin
                            hi_d = bus.i_bus_a;
                        end else if (bus.i_funct == FunctMtlo) begin
                            lo_d = bus.i_bus_a;
                        end else if (start_muldiv) begin
                            state_d   = StIter;
                            cnt_d     = CntW'(W - 1);
                            is_div_d  = op_div;
                            neg_res_d = op_signed && (bus.i_bus_a[W-1] ^ bus.i_bus_b[W-1]);
                            neg_rem_d = op_signed && bus.i_bus_a[W-1];
                            div0_d    = op_div && (bus.i_bus_b == '0);
                            opnd_d    = op_div ? abs_b : abs_a;
                            acc_d     = {{W{1'b0}}, (op_div ? abs_a : abs_b)};
                        end
                    end
                end
                StIter: begin
                    if (bus.i_flush) begin
                        state_d = StIdle;
                    end else begin
                        if (is_div_q) begin
                            acc_d = {(sub_ok ? rem_diff : rem_sh[W-1:0]), acc_q[W-2:0], sub_ok};
                        end else if (acc_q[0]) begin
                            acc_d = {add_sum, acc_q[W-1:1]};
                        end else begin
                            acc_d = {1'b0, acc_q[2*W-1:1]};
                        end
                        if (cnt_q == '0) begin
                            state_d = StFix;
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                StFix: begin
                    if (bus.i_flush) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDone;
                        if (!is_div_q) begin
                            {hi_d, lo_d} = prod_fixed;
                        end else if (div0_q) begin
                            // divisor 0 leaves remainder = |a|; re-signing restores raw a
                            lo_d = '1;
                            hi_d = neg_if(acc_q[2*W-1:W], neg_rem_q);
                        end else begin
                            lo_d = neg_if(acc_q[W-1:0], neg_res_q);
                            hi_d = neg_if(acc_q[2*W-1:W], neg_rem_q);
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    assign bus.o_stall       = ((state_q == StIdle) && start_muldiv) ||
                               (state_q == StIter) || (state_q == StFix);
    assign bus.o_done        = (state_q == StDone);
    assign bus.o_div_by_zero = (state_q == StDone) && div0_q;
    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;

endmodule
